// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with grant hold, release handshake and
// hold timeout. Drives a one-hot grant into a downstream 4-to-2 encoder.
//
// Handshake: a grant is issued one cycle after an enabled, non-empty request
// is sampled in IDLE and held until en drops, done pulses, the owner drops its
// request, or the hold limit is reached (in that priority); the release takes
// effect at the next edge and is always followed by one idle cycle.
module rr_arbiter_4 #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    own_q, own_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    gnt_q, gnt_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic          timeout_q, timeout_d;

    logic          pick_found;
    logic [1:0]    pick_idx;
    logic [1:0]    scan_idx;

    // Round-robin scan: first requester at or after ptr, wrapping 3 -> 0.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        scan_idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            scan_idx = ptr_q + 2'(i);
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    // Next-state logic: issue grants in IDLE, evaluate release order in GRANT.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        own_d     = own_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (en && pick_found) begin
                    own_d   = pick_idx;
                    gnt_d   = 4'b0001 << pick_idx;
                    cnt_d   = CNT_ONE;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!en || done || !req[own_q]) begin
                    gnt_d   = 4'b0000;
                    ptr_d   = own_q + 2'd1;
                    state_d = IDLE;
                end else if (cnt_q == HOLD_LIM) begin
                    // Only a hold-limit release is reported as a timeout.
                    gnt_d     = 4'b0000;
                    ptr_d     = own_q + 2'd1;
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = 4'b0000;
                state_d = IDLE;
            end
        endcase
        gnt_valid_d = |gnt_d;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            own_q       <= 2'd0;
            cnt_q       <= '0;
            gnt_q       <= 4'b0000;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            own_q       <= own_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter with grant hold, release handshake and hold timeout. It sits directly upstream of the 4-to-2 encoder. Its registered one-hot `gnt` vector drives the encoder's `I` input, and `gnt_valid` drives the encoder's enable `e`, so the encoder's `y` output is the index of the current owner. At most one bit of `gnt` is ever high, which satisfies the encoder's one-hot input assumption.

## Interface
Parameters:
- `HOLD_MAX`, default 15: maximum consecutive cycles a single grant may be held. Legal range is 1..255.

Ports:
- `clk`, input, 1: the single clock. Every flop in the block is clocked on its rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `en`, input, 1: arbitration enable. When low, no new grant is issued and any current grant is released.
- `req`, input, 4: request vector. Bit i is high when requester i wants the resource.
- `done`, input, 1: pulse from the current owner signalling that its transaction is complete.
- `gnt`, output, 4: registered one-hot grant, or 0000 when no grant is active.
- `gnt_valid`, output, 1: high whenever `gnt` is nonzero.
- `timeout`, output, 1: one-cycle pulse when a grant is force-released by the hold limit.

## Operation
- **State.** The FSM has two states, IDLE and GRANT. The block also holds:
  - a 2-bit priority pointer `ptr`;
  - a 2-bit owner index `own`;
  - a hold counter `cnt` of width ceil(log2(HOLD_MAX+1)).
- **Reset.** While `rst_n` is sampled low:
  - state = IDLE, `ptr` = 0, `cnt` = 0;
  - `gnt` = 0000, `gnt_valid` = 0, `timeout` = 0.
  - Reset applied mid-grant aborts the grant at that edge; no `timeout` pulse is produced.
- **IDLE.** If `en` = 1 and `req` != 0000:
  - Select the first set bit of `req` scanning `ptr`, `ptr`+1, ... modulo 4 (wrap-around 3 to 0).
  - Load `own`, set `gnt` to the one-hot encoding of `own`, set `cnt` to 1, and go to GRANT.
  - Otherwise remain in IDLE with `gnt` = 0000.
- **GRANT.** `gnt` is held stable. Release conditions are evaluated every cycle in this priority order:
  1. `en` = 0;
  2. `done` = 1;
  3. `req[own]` = 0;
  4. `cnt` == HOLD_MAX. Only this condition asserts `timeout`.
  
  If none of these holds, `cnt` increments by 1.
- **On release** (applied at the next edge):
  - `gnt` = 0000;
  - `ptr` = `own`+1 modulo 4;
  - state = IDLE;
  - `timeout` = 1 for exactly that one cycle, and only when condition 4 caused the release.
- **Fairness.** The just-served requester has the lowest priority in the next arbitration, so every persistent requester is granted within 4 grants.
- **Ignored inputs.** `done` is ignored in IDLE. Changes to `req` bits other than `req[own]` are ignored in GRANT.

## Timing
- **Grant latency.** A request sampled in IDLE produces `gnt` one cycle later.
- **Release latency.** A release condition sampled at edge N clears `gnt` after edge N.
- **Idle gap.** There is a mandatory one-cycle gap with `gnt` = 0000 between any two grants, including back-to-back grants to the same requester.
- **Hold limit.** The maximum `gnt` high time is HOLD_MAX cycles. Counting the cycles in which `gnt` is nonzero, the count is 1..HOLD_MAX.
- **Simultaneous events.**
  - `done` and `cnt` == HOLD_MAX in the same cycle: the release is normal, with `timeout` = 0.
  - `req` and `en` both dropping: the release is normal.
- **Output stability.** `gnt`, `gnt_valid` and `timeout` are all flop outputs with no combinational path from the inputs. `gnt_valid` always equals the OR of the `gnt` bits.

## Test plan
1. **Reset with requests pending.** Drive `rst_n` = 0 for 3 cycles with `req` = 1111 and `en` = 1.
   - Required: `gnt` = 0000, `gnt_valid` = 0 and `timeout` = 0 during reset.
   - Required: the first grant is 0001, one cycle after `rst_n` rises.
2. **Rotation.** Hold `req` = 1111 and pulse `done` in the second cycle of each grant.
   - Required `gnt` sequence: 0001, 0001, 0000, 0010, 0010, 0000, 0100, 0100, 0000, 1000, 1000, 0000, 0001.
   - Required: the encoder `y` follows 00, 01, 10, 11, 00.
3. **Single requester and pointer wrap.** With `ptr` = 0, drive `req` = 0100.
   - Required: `gnt` = 0100 the next cycle.
   - Then drop `req[2]`. Required: `gnt` = 0000 the next cycle and `ptr` = 3.
   - Then drive `req` = 1001. Required: `gnt` = 1000.
4. **Timeout.** With HOLD_MAX = 4, hold `req` = 0010 and `done` = 0.
   - Required: `gnt` = 0010 for exactly 4 cycles, then `gnt` = 0000 with `timeout` = 1 for 1 cycle.
   - Required: `gnt` = 0010 again on the following cycle.
5. **Enable off.** Drop `en` mid-grant while `req` = 1111.
   - Required: `gnt` = 0000 the next cycle, no `timeout`, and no new grant while `en` = 0.
6. **Reset mid-grant.** Hold `rst_n` = 0 for one cycle during a grant to requester 2.
   - Required: `gnt` = 0000 and `timeout` = 0.
   - Required: `ptr` = 0, so with `req` = 1111 the next grant is 0001.
